// File: rtl/aes_regfile_pkg.sv
// Shared constants and types for the AES Avalon-MM register file.
package aes_regfile_pkg;

  localparam logic [3:0] ADDR_KEY0     = 4'd0;
  localparam logic [3:0] ADDR_MSG_ENC0 = 4'd4;
  localparam logic [3:0] ADDR_MSG_DEC0 = 4'd8;
  localparam logic [3:0] ADDR_CTRL     = 4'd14;
  localparam logic [3:0] ADDR_STATUS   = 4'd15;

  localparam int CTRL_START = 0;
  localparam int STAT_DONE  = 0;
  localparam int STAT_BUSY  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } ctrl_state_t;

  // Byte-granular merge of a bus write into an existing word.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        res[8*b +: 8] = cur[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_regfile_byte_write.sv
// Byte-enable masked write of one bus word into a register's next value.
module aes_regfile_byte_write
  import aes_regfile_pkg::*;
(
  input  logic [31:0] cur_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  input  logic        en_i,
  output logic [31:0] nxt_o
);

  always_comb begin
    if (en_i) begin
      nxt_o = byte_merge(cur_i, wdata_i, be_i);
    end else begin
      nxt_o = cur_i;
    end
  end

endmodule

// File: rtl/aes_avalon_regfile.sv
// Avalon-MM register file feeding the AES decryption core with key/ciphertext.
// Optional interrupt output enabled by defining AES_REGFILE_IRQ_EN.
module aes_avalon_regfile
  import aes_regfile_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     AVL_CS,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic [$clog2(NREGS)-1:0] AVL_ADDR,
  input  logic [DW/8-1:0]          AVL_BYTE_EN,
  input  logic [DW-1:0]            AVL_WRITEDATA,
  output logic [DW-1:0]            AVL_READDATA,
  output logic [DW-1:0]            EXPORT_DATA,
  output logic [127:0]             AES_KEY,
  output logic [127:0]             AES_MSG_ENC,
  output logic                     AES_START,
  input  logic                     AES_DONE,
  input  logic [127:0]             AES_MSG_DEC
`ifdef AES_REGFILE_IRQ_EN
  ,output logic                    AES_IRQ
`endif
);

  logic [DW-1:0] op_q [0:7];
  logic [DW-1:0] op_d [0:7];
  logic [127:0]  dec_q, dec_d;
  logic [DW-1:0] ctrl_q, ctrl_d, ctrl_nxt_s;
  logic          done_q, done_d;
  logic          aes_start_q, aes_start_d;
  logic [DW-1:0] rdata_q, rdata_d, rd_word_s;
  ctrl_state_t   state_q, state_d;

  logic wr_s, rd_s, idle_s, busy_s;
  logic ctrl_wr_s, start_be_s, start_set_s, start_clr_s, done_set_s;

  assign wr_s        = AVL_CS & AVL_WRITE;
  assign rd_s        = AVL_CS & AVL_READ;
  assign idle_s      = (state_q == IDLE);
  assign busy_s      = (state_q == RUN);
  assign ctrl_wr_s   = wr_s & (AVL_ADDR == ADDR_CTRL);
  assign start_be_s  = ctrl_wr_s & AVL_BYTE_EN[0];
  assign start_set_s = start_be_s & AVL_WRITEDATA[CTRL_START];
  assign start_clr_s = start_be_s & ~AVL_WRITEDATA[CTRL_START];

  // Operands are frozen outside IDLE so the core sees stable inputs for a whole run.
  for (genvar i = 0; i < 8; i++) begin : g_op
    aes_regfile_byte_write u_bw (
      .cur_i   (op_q[i]),
      .wdata_i (AVL_WRITEDATA),
      .be_i    (AVL_BYTE_EN),
      .en_i    (wr_s & idle_s & (AVL_ADDR == (ADDR_KEY0 + 4'(i)))),
      .nxt_o   (op_d[i])
    );
  end

  aes_regfile_byte_write u_bw_ctrl (
    .cur_i   (ctrl_q),
    .wdata_i (AVL_WRITEDATA),
    .be_i    (AVL_BYTE_EN),
    .en_i    (ctrl_wr_s),
    .nxt_o   (ctrl_nxt_s)
  );

  always_comb begin
    ctrl_d = '0;
    ctrl_d[CTRL_START] = ctrl_nxt_s[CTRL_START];
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    dec_d      = dec_q;
    done_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_set_s) begin
          state_d = RUN;
          done_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A software abort wins over a coincident completion.
        if (start_clr_s) begin
          state_d = IDLE;
        end else if (AES_DONE) begin
          state_d    = FINISH;
          done_d     = 1'b1;
          dec_d      = AES_MSG_DEC;
          done_set_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FINISH: begin
        if (start_clr_s) begin
          state_d = IDLE;
        end else begin
          state_d = FINISH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    aes_start_d = (state_d != IDLE);
  end

  always_comb begin
    rd_word_s = '0;
    case (AVL_ADDR)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: rd_word_s = op_q[AVL_ADDR[2:0]];
      ADDR_MSG_DEC0:        rd_word_s = dec_q[127:96];
      ADDR_MSG_DEC0 + 4'd1: rd_word_s = dec_q[95:64];
      ADDR_MSG_DEC0 + 4'd2: rd_word_s = dec_q[63:32];
      ADDR_MSG_DEC0 + 4'd3: rd_word_s = dec_q[31:0];
      ADDR_CTRL:            rd_word_s = ctrl_q;
      ADDR_STATUS: begin
        rd_word_s[STAT_DONE] = done_q;
        rd_word_s[STAT_BUSY] = busy_s;
      end
      default:              rd_word_s = '0;
    endcase
    if (rd_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < 8; k++) begin
        op_q[k] <= '0;
      end
      dec_q       <= '0;
      ctrl_q      <= '0;
      done_q      <= 1'b0;
      aes_start_q <= 1'b0;
      rdata_q     <= '0;
      state_q     <= IDLE;
    end else begin
      for (int k = 0; k < 8; k++) begin
        op_q[k] <= op_d[k];
      end
      dec_q       <= dec_d;
      ctrl_q      <= ctrl_d;
      done_q      <= done_d;
      aes_start_q <= aes_start_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
    end
  end

  assign AVL_READDATA = rdata_q;
  assign AES_START    = aes_start_q;
  assign AES_KEY      = {op_q[0], op_q[1], op_q[2], op_q[3]};
  assign AES_MSG_ENC  = {op_q[4], op_q[5], op_q[6], op_q[7]};
  assign EXPORT_DATA  = {op_q[0][31:16], op_q[3][15:0]};

`ifdef AES_REGFILE_IRQ_EN
  logic irq_q, irq_d;
  logic irq_ack_s;

  assign irq_ack_s = wr_s & (AVL_ADDR == ADDR_STATUS) & AVL_BYTE_EN[0] &
                     AVL_WRITEDATA[STAT_DONE];

  // Setting on completion takes priority over any acknowledge in the same cycle.
  always_comb begin
    if (done_set_s) begin
      irq_d = 1'b1;
    end else if (irq_ack_s | start_set_s) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign AES_IRQ = irq_q;
`endif

endmodule

// File: tb/tb_aes_avalon_regfile.sv
// Self-checking bench for aes_avalon_regfile: vector table, directed run sequences, random ops vs model.
module tb_aes_avalon_regfile;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA, EXPORT_DATA;
  logic [127:0] AES_KEY, AES_MSG_ENC, AES_MSG_DEC;
  logic         AES_START, AES_DONE;
`ifdef AES_REGFILE_IRQ_EN
  logic         AES_IRQ;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  aes_avalon_regfile dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .EXPORT_DATA   (EXPORT_DATA),
    .AES_KEY       (AES_KEY),
    .AES_MSG_ENC   (AES_MSG_ENC),
    .AES_START     (AES_START),
    .AES_DONE      (AES_DONE),
    .AES_MSG_DEC   (AES_MSG_DEC)
`ifdef AES_REGFILE_IRQ_EN
    ,.AES_IRQ      (AES_IRQ)
`endif
  );

  // Reference model: register contents plus "run in progress" / "result held" flags.
  logic [31:0]  m_reg [0:7];
  logic [127:0] m_dec;
  logic         m_start, m_done, m_active, m_held, m_irq;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_reg[k] = 32'h0;
    m_dec = 128'h0; m_start = 1'b0; m_done = 1'b0;
    m_active = 1'b0; m_held = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a < 4'd8) begin
      if (!m_active && !m_held) m_reg[a[2:0]] = merge(m_reg[a[2:0]], d, be);
    end else if (a == 4'd14 && be[0]) begin
      m_start = d[0];
      if (d[0]) begin
        m_irq = 1'b0;
        if (!m_active && !m_held) begin m_active = 1'b1; m_done = 1'b0; end
      end else begin
        m_active = 1'b0; m_held = 1'b0;
      end
    end else if (a == 4'd15 && be[0] && d[0]) begin
      m_irq = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd8:    return m_dec[127:96];
      4'd9:    return m_dec[95:64];
      4'd10:   return m_dec[63:32];
      4'd11:   return m_dec[31:0];
      4'd12, 4'd13: return 32'h0;
      4'd14:   return {31'h0, m_start};
      4'd15:   return {30'h0, m_active, m_done};
      default: return m_reg[a[2:0]];
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".start"}, {127'h0, AES_START}, {127'h0, m_active | m_held});
    check({tag, ".key"}, AES_KEY, {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
    check({tag, ".enc"}, AES_MSG_ENC, {m_reg[4], m_reg[5], m_reg[6], m_reg[7]});
    check({tag, ".export"}, {96'h0, EXPORT_DATA}, {96'h0, m_reg[0][31:16], m_reg[3][15:0]});
`ifdef AES_REGFILE_IRQ_EN
    check({tag, ".irq"}, {127'h0, AES_IRQ}, {127'h0, m_irq});
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK); RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    model_write(a, d, be);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic read_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, {96'h0, d}, {96'h0, exp});
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1;
    AVL_ADDR = a; AVL_WRITEDATA = wd; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    rd = AVL_READDATA;
    model_write(a, wd, be);
  endtask

  task automatic pulse_done(input logic [127:0] msg);
    @(negedge CLK);
    AES_DONE = 1'b1; AES_MSG_DEC = msg;
    @(negedge CLK);
    AES_DONE = 1'b0;
    if (m_active) begin
      m_dec = msg; m_done = 1'b1; m_active = 1'b0; m_held = 1'b1; m_irq = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rd, pre;
    logic [127:0] msg;
    logic [3:0]   a, be;
    logic [31:0]  d;
    int           op;

    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = 4'h0; AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = 32'h0;
    AES_DONE = 1'b0; AES_MSG_DEC = 128'h0;

    tbl[0] = '{4'd0,  32'hAABBCCDD, 4'b0101, 32'h00BB00DD};
    tbl[1] = '{4'd0,  32'h11223344, 4'b1010, 32'h11BB33DD};
    tbl[2] = '{4'd3,  32'h55667788, 4'b1111, 32'h55667788};
    tbl[3] = '{4'd12, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    tbl[4] = '{4'd8,  32'hFFFFFFFF, 4'b1111, 32'h00000000};
    tbl[5] = '{4'd14, 32'hFFFFFFFE, 4'b1111, 32'h00000000};
    tbl[6] = '{4'd15, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    tbl[7] = '{4'd7,  32'h0000FFFF, 4'b0011, 32'h0000FFFF};
    tbl[8] = '{4'd14, 32'h12345678, 4'b1110, 32'h00000000};

    // Reset state: every address reads zero.
    do_reset();
    check("reset.start", {127'h0, AES_START}, 128'h0);
    check("reset.readdata", {96'h0, AVL_READDATA}, 128'h0);
    for (int i = 0; i < 16; i++) read_expect($sformatf("reset.rd%0d", i), 4'(i), 32'h0);

    // Byte-enable vector table.
    for (int i = 0; i < 9; i++) begin
      bus_write(tbl[i].addr, tbl[i].data, tbl[i].be);
      read_expect($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
      if (i == 0) check("vec0.export", {96'h0, EXPORT_DATA}, {96'h0, 32'h00BB0000});
      if (i == 2) check("vec2.export", {96'h0, EXPORT_DATA}, {96'h0, 32'h11BB7788});
    end

    // Same-cycle read and write returns the pre-write value.
    bus_write(4'd5, 32'h12345678, 4'hF);
    bus_rw(4'd5, 32'hCAFEBABE, 4'hF, rd);
    check("rw.pre", {96'h0, rd}, {96'h0, 32'h12345678});
    read_expect("rw.post", 4'd5, 32'hCAFEBABE);

    // Full run with a stub core.
    do_reset();
    bus_write(4'd0, 32'h00010203, 4'hF); bus_write(4'd1, 32'h04050607, 4'hF);
    bus_write(4'd2, 32'h08090a0b, 4'hF); bus_write(4'd3, 32'h0c0d0e0f, 4'hF);
    bus_write(4'd4, 32'h69c4e0d8, 4'hF); bus_write(4'd5, 32'h6a7b0430, 4'hF);
    bus_write(4'd6, 32'hd8cdb780, 4'hF); bus_write(4'd7, 32'h70b4c55a, 4'hF);
    check("run.start_pre", {127'h0, AES_START}, 128'h0);
    bus_write(4'd14, 32'h1, 4'hF);
    check("run.start", {127'h0, AES_START}, {127'h0, 1'b1});
    check("run.key", AES_KEY, 128'h000102030405060708090a0b0c0d0e0f);
    check("run.enc", AES_MSG_ENC, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    bus_write(4'd4, 32'hFFFFFFFF, 4'hF);
    read_expect("run.reg4_frozen", 4'd4, 32'h69c4e0d8);
    read_expect("run.busy", 4'd15, 32'h2);
    repeat (22) @(negedge CLK);
    check("run.enc_stable", AES_MSG_ENC, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    pulse_done(128'h00112233445566778899aabbccddeeff);
`ifdef AES_REGFILE_IRQ_EN
    check("run.irq_set", {127'h0, AES_IRQ}, {127'h0, 1'b1});
`endif
    read_expect("run.status", 4'd15, 32'h1);
    read_expect("run.reg8", 4'd8, 32'h00112233);
    read_expect("run.reg11", 4'd11, 32'hccddeeff);
    check("run.start_finish", {127'h0, AES_START}, {127'h0, 1'b1});
`ifdef AES_REGFILE_IRQ_EN
    bus_write(4'd15, 32'h1, 4'hF);
    check("irq.ack", {127'h0, AES_IRQ}, 128'h0);
    pulse_done(128'hdeadbeef000000000000000000000000);
    check("irq.finish_done", {127'h0, AES_IRQ}, 128'h0);
`else
    pulse_done(128'hdeadbeef000000000000000000000000);
`endif
    read_expect("run.reg8_kept", 4'd8, 32'h00112233);
    bus_write(4'd14, 32'h0, 4'hF);
    check("run.start_drop", {127'h0, AES_START}, 128'h0);
    read_expect("run.status_idle", 4'd15, 32'h1);

    // Abort during a run.
    do_reset();
    bus_write(4'd0, 32'h13572468, 4'hF);
    bus_write(4'd14, 32'h1, 4'hF);
    read_expect("abort.busy", 4'd15, 32'h2);
    bus_write(4'd14, 32'h0, 4'hF);
    check("abort.start", {127'h0, AES_START}, 128'h0);
    read_expect("abort.status", 4'd15, 32'h0);
    pulse_done(128'hffffffffffffffffffffffffffffffff);
    read_expect("abort.reg8", 4'd8, 32'h0);
    read_expect("abort.status2", 4'd15, 32'h0);

    // Reset during a run.
    bus_write(4'd3, 32'h0000BEEF, 4'hF);
    bus_write(4'd14, 32'h1, 4'hF);
    read_expect("rst.pre", 4'd0, 32'h13572468);
    do_reset();
    check("rst.start", {127'h0, AES_START}, 128'h0);
    check("rst.key", AES_KEY, 128'h0);
    check("rst.enc", AES_MSG_ENC, 128'h0);
    check("rst.export", {96'h0, EXPORT_DATA}, 128'h0);
    check("rst.readdata", {96'h0, AVL_READDATA}, 128'h0);
    read_expect("rst.status", 4'd15, 32'h0);
    read_expect("rst.ctrl", 4'd14, 32'h0);
    read_expect("rst.reg0", 4'd0, 32'h0);

    // Randomized operations against the model.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 9));
      a  = 4'($urandom_range(0, 15));
      be = 4'($urandom_range(0, 15));
      d  = $urandom;
      if (op <= 2) begin
        bus_write(a, d, be);
      end else if (op == 3) begin
        bus_write(4'd14, d, be | 4'b0001);
      end else if (op <= 7) begin
        pre = model_read(a);
        read_expect($sformatf("rand%0d.rd%0d", it, a), a, pre);
      end else if (op == 8) begin
        msg = {$urandom, $urandom, $urandom, $urandom};
        pulse_done(msg);
      end else begin
        pre = model_read(a);
        bus_rw(a, d, be, rd);
        check($sformatf("rand%0d.rw%0d", it, a), {96'h0, rd}, {96'h0, pre});
      end
      check_outputs($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
